// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: word loads/stores over a req/ack bus,
// upstream stall while an access is outstanding, abort on misalignment or timeout.
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_CTRL,
  input  logic [4:0]  WB_CTRL,
  input  logic [68:0] MEM_DATA,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        MEM_STALL,
  output logic [4:0]  o_WB_CTRL,
  output logic [36:0] o_WB_DATA,
  output logic [37:0] MEM_BACK,
  output logic        o_ADDR_ERR,
  output logic        o_BUS_ERR
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [4:0]  rw;
  logic [31:0] exout, sdata;
  logic        access, misaligned;

  assign rw     = MEM_DATA[68:64];
  assign exout  = MEM_DATA[63:32];
  assign sdata  = MEM_DATA[31:0];
  assign access = MEM_CTRL | WB_CTRL[1];
  assign misaligned = |exout[1:0];

  logic [0:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  wb_ctrl_q, wb_ctrl_d;
  logic [36:0] wb_data_q, wb_data_d;
  logic        addr_err_q, addr_err_d;
  logic        bus_err_q, bus_err_d;
  logic        req, stall, complete, bubble;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req        = 1'b0;
    stall      = 1'b0;
    complete   = 1'b0;
    bubble     = 1'b0;
    addr_err_d = 1'b0;
    bus_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            bubble     = 1'b1;
            addr_err_d = 1'b1;
          end else begin
            req = 1'b1;
            if (dmem_ack) begin
              complete = 1'b1;
            end else begin
              stall   = 1'b1;
              bubble  = 1'b1;
              state_d = WAIT;
              cnt_d   = 8'd0;
            end
          end
        end
      end
      default: begin
        req = 1'b1;
        // Ack in the final WAIT cycle still counts as a completion.
        if (dmem_ack) begin
          complete = 1'b1;
          state_d  = IDLE;
          cnt_d    = 8'd0;
        end else if (cnt_q < LAST) begin
          cnt_d  = cnt_q + 8'd1;
          stall  = 1'b1;
          bubble = 1'b1;
        end else begin
          bubble    = 1'b1;
          bus_err_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = 8'd0;
        end
      end
    endcase
    wb_ctrl_d = bubble ? 5'd0 : WB_CTRL;
    wb_data_d = {rw, (complete && WB_CTRL[1]) ? dmem_rdata : exout};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      wb_ctrl_q  <= 5'd0;
      wb_data_q  <= 37'd0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_ctrl_q  <= wb_ctrl_d;
      wb_data_q  <= wb_data_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Gated by reset so an in-flight request drops the moment reset asserts.
  assign dmem_req   = req & rst;
  assign MEM_STALL  = stall & rst;
  assign dmem_we    = MEM_CTRL;
  assign dmem_addr  = exout;
  assign dmem_wdata = sdata;

  assign o_WB_CTRL  = wb_ctrl_q;
  assign o_WB_DATA  = wb_data_q;
  assign o_ADDR_ERR = addr_err_q;
  assign o_BUS_ERR  = bus_err_q;
  assign MEM_BACK   = {WB_CTRL[0] & ~WB_CTRL[1], rw, exout};

endmodule

// File: tb/tb_mem_stage.sv
// Directed cycle-by-cycle vectors for mem_stage (TIMEOUT=4) plus reset sequences.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_CTRL;
  logic [4:0]  WB_CTRL;
  logic [68:0] MEM_DATA;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        MEM_STALL, o_ADDR_ERR, o_BUS_ERR;
  logic [4:0]  o_WB_CTRL;
  logic [36:0] o_WB_DATA;
  logic [37:0] MEM_BACK;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .MEM_CTRL(MEM_CTRL), .WB_CTRL(WB_CTRL), .MEM_DATA(MEM_DATA),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .MEM_STALL(MEM_STALL),
    .o_WB_CTRL(o_WB_CTRL), .o_WB_DATA(o_WB_DATA), .MEM_BACK(MEM_BACK),
    .o_ADDR_ERR(o_ADDR_ERR), .o_BUS_ERR(o_BUS_ERR)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mc;
    logic [4:0]  wc;
    logic [4:0]  rw;
    logic [31:0] ex;
    logic [31:0] sd;
    logic        ack;
    logic [31:0] rd;
    logic        e_req;
    logic        e_stall;
    logic [4:0]  e_wbc;
    logic [36:0] e_wbd;
    logic        dchk;
    logic        e_aerr;
    logic        e_berr;
    logic        e_fwd;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic mc, input logic [4:0] wc, input logic [4:0] rw,
                       input logic [31:0] ex, input logic [31:0] sd,
                       input logic ack, input logic [31:0] rd);
    MEM_CTRL   = mc;
    WB_CTRL    = wc;
    MEM_DATA   = {rw, ex, sd};
    dmem_ack   = ack;
    dmem_rdata = rd;
  endtask

  initial begin
    //            mc  wc        rw     ex          sd            ack  rd            req  stl  wbc       wbd                          dchk aerr berr fwd
    // ALU op forwarding
    vecs[0]  = '{1'b0, 5'b00001, 5'd5, 32'h7,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 5'b00001, {5'd5, 32'h7},              1'b1, 1'b0, 1'b0, 1'b1};
    // zero-wait store
    vecs[1]  = '{1'b1, 5'b00000, 5'd0, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1, 1'b0, 5'b00000, {5'd0, 32'h10},             1'b1, 1'b0, 1'b0, 1'b0};
    // 3-wait load
    vecs[2]  = '{1'b0, 5'b00011, 5'd8, 32'h20, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 5'b00000, 37'd0,                      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'b00011, 5'd8, 32'h20, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 5'b00000, 37'd0,                      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 5'b00011, 5'd8, 32'h20, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 5'b00000, 37'd0,                      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'b00011, 5'd8, 32'h20, 32'h0,        1'b1, 32'h12345678, 1'b1, 1'b0, 5'b00011, {5'd8, 32'h12345678},       1'b1, 1'b0, 1'b0, 1'b0};
    // misaligned load
    vecs[6]  = '{1'b0, 5'b00011, 5'd9, 32'h22, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 5'b00000, 37'd0,                      1'b0, 1'b1, 1'b0, 1'b0};
    // no access, stray ack ignored, upper ctrl bits pass through
    vecs[7]  = '{1'b0, 5'b10100, 5'd3, 32'h44, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 5'b10100, {5'd3, 32'h44},             1'b1, 1'b0, 1'b0, 1'b0};
    // zero-wait load to rw=5: never forwards
    vecs[8]  = '{1'b0, 5'b00011, 5'd5, 32'h30, 32'h0,        1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 5'b00011, {5'd5, 32'hCAFEF00D},       1'b1, 1'b0, 1'b0, 1'b0};
    // back-to-back 1-wait loads
    vecs[9]  = '{1'b0, 5'b00011, 5'd1, 32'h40, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 5'b00000, 37'd0,                      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'b00011, 5'd1, 32'h40, 32'h0,        1'b1, 32'hAAAA0001, 1'b1, 1'b0, 5'b00011, {5'd1, 32'hAAAA0001},       1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 5'b00011, 5'd2, 32'h44, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 5'b00000, 37'd0,                      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 5'b00011, 5'd2, 32'h44, 32'h0,        1'b1, 32'hBBBB0002, 1'b1, 1'b0, 5'b00011, {5'd2, 32'hBBBB0002},       1'b1, 1'b0, 1'b0, 1'b0};
    // store with regWrite, ack on the 4th WAIT cycle completes normally
    vecs[13] = '{1'b1, 5'b00001, 5'd6, 32'h50, 32'h11112222, 1'b0, 32'h0,        1'b1, 1'b1, 5'b00000, 37'd0,                      1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 5'b00001, 5'd6, 32'h50, 32'h11112222, 1'b0, 32'h0,        1'b1, 1'b1, 5'b00000, 37'd0,                      1'b0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 5'b00001, 5'd6, 32'h50, 32'h11112222, 1'b0, 32'h0,        1'b1, 1'b1, 5'b00000, 37'd0,                      1'b0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 5'b00001, 5'd6, 32'h50, 32'h11112222, 1'b0, 32'h0,        1'b1, 1'b1, 5'b00000, 37'd0,                      1'b0, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 5'b00001, 5'd6, 32'h50, 32'h11112222, 1'b1, 32'h99999999, 1'b1, 1'b0, 5'b00001, {5'd6, 32'h50},             1'b1, 1'b0, 1'b0, 1'b1};
    // store timeout: 4 stall cycles, abort on the 4th WAIT cycle
    vecs[18] = '{1'b1, 5'b00000, 5'd0, 32'h60, 32'h5555AAAA, 1'b0, 32'h0,        1'b1, 1'b1, 5'b00000, 37'd0,                      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 5'b00000, 5'd0, 32'h60, 32'h5555AAAA, 1'b0, 32'h0,        1'b1, 1'b1, 5'b00000, 37'd0,                      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 5'b00000, 5'd0, 32'h60, 32'h5555AAAA, 1'b0, 32'h0,        1'b1, 1'b1, 5'b00000, 37'd0,                      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 5'b00000, 5'd0, 32'h60, 32'h5555AAAA, 1'b0, 32'h0,        1'b1, 1'b1, 5'b00000, 37'd0,                      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 5'b00000, 5'd0, 32'h60, 32'h5555AAAA, 1'b0, 32'h0,        1'b1, 1'b0, 5'b00000, 37'd0,                      1'b0, 1'b0, 1'b1, 1'b0};
    // back to idle: request gone, error pulse over
    vecs[23] = '{1'b0, 5'b00001, 5'd4, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 5'b00001, {5'd4, 32'h0},              1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state, with a load presented to show the request is gated.
    rst = 1'b0;
    drive(1'b0, 5'b00011, 5'd8, 32'h20, 32'h0, 1'b0, 32'h0);
    #2;
    chk("rst_req", {63'd0, dmem_req}, 64'd0);
    chk("rst_stall", {63'd0, MEM_STALL}, 64'd0);
    chk("rst_wbc", {59'd0, o_WB_CTRL}, 64'd0);
    chk("rst_wbd", {27'd0, o_WB_DATA}, 64'd0);
    chk("rst_errs", {62'd0, o_ADDR_ERR, o_BUS_ERR}, 64'd0);
    drive(1'b0, 5'b00000, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].mc, vecs[i].wc, vecs[i].rw, vecs[i].ex, vecs[i].sd, vecs[i].ack, vecs[i].rd);
      #1;
      chk($sformatf("v%0d_req", i), {63'd0, dmem_req}, {63'd0, vecs[i].e_req});
      chk($sformatf("v%0d_stall", i), {63'd0, MEM_STALL}, {63'd0, vecs[i].e_stall});
      chk($sformatf("v%0d_back", i), {26'd0, MEM_BACK}, {26'd0, vecs[i].e_fwd, vecs[i].rw, vecs[i].ex});
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_bus", i), {dmem_we, dmem_addr[30:0], dmem_wdata},
            {vecs[i].mc, vecs[i].ex[30:0], vecs[i].sd});
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wbc", i), {59'd0, o_WB_CTRL}, {59'd0, vecs[i].e_wbc});
      if (vecs[i].dchk) chk($sformatf("v%0d_wbd", i), {27'd0, o_WB_DATA}, {27'd0, vecs[i].e_wbd});
      chk($sformatf("v%0d_aerr", i), {63'd0, o_ADDR_ERR}, {63'd0, vecs[i].e_aerr});
      chk($sformatf("v%0d_berr", i), {63'd0, o_BUS_ERR}, {63'd0, vecs[i].e_berr});
    end

    // Reset asserted mid-WAIT drops the request immediately, no error pulse.
    @(negedge clk);
    drive(1'b0, 5'b00011, 5'd4, 32'h70, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk("mw_pre_stall", {63'd0, MEM_STALL}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mw_req_drop", {63'd0, dmem_req}, 64'd0);
    chk("mw_stall_drop", {63'd0, MEM_STALL}, 64'd0);
    chk("mw_wbc", {59'd0, o_WB_CTRL}, 64'd0);
    @(negedge clk);
    drive(1'b0, 5'b00001, 5'd2, 32'h8, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    chk("mw_idle_req", {63'd0, dmem_req}, 64'd0);
    @(posedge clk);
    #1;
    chk("mw_idle_wbc", {59'd0, o_WB_CTRL}, 64'd1);
    chk("mw_idle_wbd", {27'd0, o_WB_DATA}, {27'd0, 5'd2, 32'h8});
    chk("mw_no_berr", {63'd0, o_BUS_ERR}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
